c1908_resp_checker: RTL

- Response-side counterpart to the c1908 stimulus path: samples the 25-bit c1908 output bus once per applied vector and compares it against a preloaded golden response memory.
- Accumulates a mismatch count, the first failing vector index, and a MISR signature of all sampled responses.
- Sits beside the DUT in aging experiments so fresh-vs-aged runs are judged in hardware rather than by offline file diff.

---
 rtl/c1908_resp_checker.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/c1908_resp_checker.sv
// c1908 response checker: samples the DUT response bus once per applied
// vector, compares it with a preloaded golden word, and accumulates a
// saturating mismatch count, the first failing index and a MISR signature.
module c1908_resp_checker #(
  parameter int OUT_WIDTH  = 25,
  parameter int VEC_LENGTH = 7,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int SETTLE     = 1,
  parameter logic [OUT_WIDTH-1:0] MISR_POLY = OUT_WIDTH'(25'h1000004)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exp_wr_en,
  input  logic [ADDR_WIDTH-1:0] exp_wr_addr,
  input  logic [OUT_WIDTH-1:0]  exp_wr_data,
  input  logic                  start,
  input  logic                  vec_valid,
  input  logic [OUT_WIDTH-1:0]  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_idx,
  output logic                  first_err_valid,
  output logic                  overrun,
  output logic [OUT_WIDTH-1:0]  signature,
  output logic [ADDR_WIDTH-1:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, ARMED, SETTLING, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VEC_LENGTH - 1);
  // The counter holds the number of cycles still to wait; the sample is
  // taken when it reads zero, SETTLE cycles after the vec_valid pulse.
  localparam logic [3:0] SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] misr_step(input logic [OUT_WIDTH-1:0] s,
                                                      input logic [OUT_WIDTH-1:0] d);
    return {s[OUT_WIDTH-2:0], 1'b0} ^ (s[OUT_WIDTH-1] ? MISR_POLY : '0) ^ d;
  endfunction

  logic [OUT_WIDTH-1:0]  golden [2**ADDR_WIDTH];
  logic [OUT_WIDTH-1:0]  exp_word;
  logic                  mismatch;
  logic                  last_vec;

  state_t                state, state_nx;
  logic [3:0]            settle_cnt, settle_cnt_nx;
  logic                  do_sample, do_clear, ovr_set;

  logic [CNT_WIDTH-1:0]  err_nx;
  logic [ADDR_WIDTH-1:0] fidx_nx;
  logic                  fvld_nx;
  logic                  ovr_nx;
  logic [OUT_WIDTH-1:0]  sig_nx;
  logic [ADDR_WIDTH-1:0] idx_nx;
  logic                  pass_nx;

  assign exp_word = golden[vec_idx];
  assign mismatch = (dut_out != exp_word);
  assign last_vec = (vec_idx == LAST_IDX);
  assign busy     = (state == ARMED) || (state == SETTLING);
  assign done     = (state == DONE);

  // Golden memory: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (exp_wr_en && state == IDLE) begin
      golden[exp_wr_addr] <= exp_wr_data;
    end
  end

  // Next-state logic and sample/clear/overrun strobes.
  always_comb begin
    state_nx      = state;
    settle_cnt_nx = settle_cnt;
    do_sample     = 1'b0;
    do_clear      = 1'b0;
    ovr_set       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          do_clear = 1'b1;
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (vec_valid) begin
          if (SETTLE == 0) begin
            do_sample = 1'b1;
            state_nx  = last_vec ? DONE : ARMED;
          end else begin
            settle_cnt_nx = SETTLE_LD;
            state_nx      = SETTLING;
          end
        end
      end
      SETTLING: begin
        if (vec_valid) begin
          ovr_set = 1'b1;
        end
        if (settle_cnt == 4'd0) begin
          do_sample = 1'b1;
          state_nx  = last_vec ? DONE : ARMED;
        end else begin
          settle_cnt_nx = settle_cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the result registers for clear, sample and hold.
  always_comb begin
    err_nx  = err_count;
    fidx_nx = first_err_idx;
    fvld_nx = first_err_valid;
    ovr_nx  = overrun | ovr_set;
    sig_nx  = signature;
    idx_nx  = vec_idx;
    if (do_clear) begin
      err_nx  = '0;
      fidx_nx = '0;
      fvld_nx = 1'b0;
      ovr_nx  = 1'b0;
      sig_nx  = '0;
      idx_nx  = '0;
    end else if (do_sample) begin
      if (mismatch) begin
        err_nx = sat_inc(err_count);
        if (!first_err_valid) begin
          fidx_nx = vec_idx;
          fvld_nx = 1'b1;
        end
      end
      sig_nx = misr_step(signature, dut_out);
      idx_nx = vec_idx + 1'b1;
    end
    // pass is judged on entry to DONE and held there; zero elsewhere.
    pass_nx = 1'b0;
    if (state_nx == DONE) begin
      pass_nx = (state == DONE) ? pass : ((err_nx == '0) && !ovr_nx);
    end
  end

  // State and result registers; reset discards any pending sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      settle_cnt      <= 4'd0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      overrun         <= 1'b0;
      signature       <= '0;
      vec_idx         <= '0;
      pass            <= 1'b0;
    end else begin
      state           <= state_nx;
      settle_cnt      <= settle_cnt_nx;
      err_count       <= err_nx;
      first_err_idx   <= fidx_nx;
      first_err_valid <= fvld_nx;
      overrun         <= ovr_nx;
      signature       <= sig_nx;
      vec_idx         <= idx_nx;
      pass            <= pass_nx;
    end
  end

endmodule
